// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin muxing arbiter (mux_rr_arbiter).
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // First set request bit scanning upward from ptr+1, wrapping; the nearest candidate is written last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                                 input logic [SEL_W-1:0] ptr_v);
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] win;
        win = ptr_v;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr_v + SEL_W'(k);
            if (req_v[cand]) begin
                win = cand;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 single-bit multiplexer used for the arbiter data path.
module mux4 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic [1:0] sel,
    output logic       y
);

    // Select one of four data bits.
    always_comb begin
        y = 1'b0;
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded hold time and a one-cycle gap between grants, steering din[sel] to y.
// Define MUX_RR_ARBITER_ASSERT_EN to compile in embedded protocol assertions.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             y
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic [7:0]       hold_cnt_r;
    logic [7:0]       hold_nxt_s;
    logic [N_REQ-1:0] gnt_nxt_s;
    logic [SEL_W-1:0] sel_nxt_s;
    logic             busy_nxt_s;
    logic             enter_s;
    logic [SEL_W-1:0] winner_s;
    logic             mux_y_s;

    assign winner_s = rr_pick(req, ptr_r);

    // Next-state and next-output decode; every grant entry goes through the enter_s path.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_cnt_r;
        gnt_nxt_s   = gnt;
        sel_nxt_s   = sel;
        busy_nxt_s  = busy;
        enter_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    enter_s = 1'b1;
                end else begin
                    gnt_nxt_s  = 4'b0000;
                    busy_nxt_s = 1'b0;
                end
            end
            GRANT: begin
                if (!req[sel] || (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = GAP;
                    gnt_nxt_s   = 4'b0000;
                    busy_nxt_s  = 1'b1;
                end else if (hold_cnt_r != 8'hFF) begin
                    hold_nxt_s = hold_cnt_r + 8'd1;
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            GAP: begin
                if (req != 4'b0000) begin
                    enter_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = 4'b0000;
                    busy_nxt_s  = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 4'b0000;
                busy_nxt_s  = 1'b0;
            end
        endcase
        if (enter_s) begin
            state_nxt_s = GRANT;
            ptr_nxt_s   = winner_s;
            hold_nxt_s  = 8'd0;
            gnt_nxt_s   = 4'b0001 << winner_s;
            sel_nxt_s   = winner_s;
            busy_nxt_s  = 1'b1;
        end else begin
            ptr_nxt_s = ptr_nxt_s;
        end
    end

    // State and registered outputs; reset makes requester 0 highest priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 2'd3;
            hold_cnt_r <= 8'd0;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            gnt        <= gnt_nxt_s;
            sel        <= sel_nxt_s;
            busy       <= busy_nxt_s;
        end
    end

    mux4 u_mux (
        .a   (din[0]),
        .b   (din[1]),
        .c   (din[2]),
        .d   (din[3]),
        .sel (sel),
        .y   (mux_y_s)
    );

    assign y = mux_y_s & (|gnt);

`ifdef MUX_RR_ARBITER_ASSERT_EN
    logic [8:0] grant_run_r;

    // Length of the current grant, counting cycles already completed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_run_r <= 9'd0;
        end else if (gnt != 4'b0000) begin
            grant_run_r <= (grant_run_r == 9'h1FF) ? grant_run_r : grant_run_r + 9'd1;
        end else begin
            grant_run_r <= 9'd0;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_sel: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt != 4'b0000) |-> (gnt == (4'b0001 << sel)));
    a_sel_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt != 4'b0000) && ($past(gnt) != 4'b0000)) |-> (sel == $past(sel)));
    a_max_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt != 4'b0000) |-> (grant_run_r < 9'(MAX_HOLD)));

    for (genvar i = 0; i < N_REQ; i++) begin : g_rise
        a_rise_req: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(gnt[i]) |-> $past(req[i]));
    end
`endif

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive GRANT cycles per requester; legal range 2..255.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  4  request per requester; bit i belongs to requester i.
REQ-005 Port: din  input  4  data bit per requester; din[i] is routed when requester i is granted.
REQ-006 Port: gnt  output  4  one-hot grant, or all-zero; registered.
REQ-007 Port: sel  output  2  mux select, the binary index of the current or most recent grant; registered.
REQ-008 Port: busy  output  1  high while the FSM is in GRANT or GAP; registered.
REQ-009 Port: y  output  1  din[sel] while gnt is non-zero, else 0; combinational from registered sel and gnt.

Function
REQ-010 FSM states: IDLE, GRANT, GAP; exactly one state is active at all times.
REQ-011 IDLE, req==0 -> stay in IDLE; gnt=0, busy=0, sel holds its value.
REQ-012 IDLE, req!=0 -> GRANT on the next edge; the winner appears on gnt/sel with 1-cycle latency from the sampled req.
REQ-013 Winner selection: rotating priority starting at index ptr+1 mod 4 and wrapping; the first set req bit wins.
REQ-014 On each transition into GRANT: ptr<=winner, hold_cnt<=0, gnt<=1<<winner, sel<=winner.
REQ-015 In GRANT: hold_cnt increments by 1 each cycle and saturates; sel and gnt stay constant.
REQ-016 GRANT -> GAP when req[sel]==0 or hold_cnt==MAX_HOLD-1, so a grant lasts 1..MAX_HOLD cycles.
REQ-017 In GAP, for exactly 1 cycle: gnt=0, busy=1, sel unchanged, so there is no select change while a grant is active.
REQ-018 GAP, req!=0 -> GRANT with the REQ-013 winner; GAP, req==0 -> IDLE.
REQ-019 A requester that is timed out and still requesting loses to any other requester at the next arbitration; if it is the only requester, it is re-granted after the GAP cycle.
REQ-020 sel changes only on the edge that enters GRANT.
REQ-021 Requests that arrive or drop in the same cycle as a release are evaluated in GAP, not in the release cycle.

Reset
REQ-022 When rst_n==0 at an edge: state<=IDLE, gnt<=0, sel<=0, busy<=0, hold_cnt<=0, ptr<=3 (requester 0 has highest priority first).
REQ-023 Reset asserted mid-GRANT or mid-GAP takes effect at that edge; no GAP cycle is inserted.
REQ-024 After reset, y=0 until the first grant.

Configuration
REQ-025 Macro MUX_RR_ARBITER_ASSERT_EN: when defined, embedded SVA checks are compiled in, as listed in REQ-026.
REQ-026 SVA checks, all disabled while rst_n==0:
- gnt is $onehot0.
- gnt!=0 implies gnt==1<<sel.
- sel is $stable whenever gnt is non-zero in consecutive cycles.
- A grant never exceeds MAX_HOLD cycles.
- A rise of gnt[i] implies req[i] was high in the previous cycle.
REQ-027 When the macro is undefined, no assertion code is present, and ports and functional behaviour are identical.

Structure
REQ-028 Shared package mux_arb_pkg contains:
- typedef enum state_t {IDLE, GRANT, GAP}
- localparam N_REQ=4
- localparam SEL_W=2
REQ-029 The y datapath is a single instance of the team's existing 4:1 mux (a,b,c,d,sel,y), named u_mux, with its output gated by |gnt; no other sub-modules.

Verification
REQ-030 Reset, then req=4'b0000 for 5 cycles -> gnt=0, sel=0, busy=0, y=0 throughout.
REQ-031 req=4'b0101 held, MAX_HOLD=4 -> grants rotate: requester 0 for 4 cycles, GAP, requester 2 for 4 cycles, GAP, requester 0 again.
REQ-032 req=4'b0010 for 2 cycles then 0, din=4'b0010 -> gnt=4'b0010 for 2 cycles, y=1 during them, then GAP, then IDLE.
REQ-033 Only req[3] held, MAX_HOLD=4 -> gnt=4'b1000 for 4 cycles, 1 GAP cycle, re-granted; this repeats.
REQ-034 rst_n driven low on the 2nd GRANT cycle -> gnt=0 and sel=0 at that edge; after release with req=4'b1111, requester 0 is granted first.
REQ-035 All scenarios are run with MUX_RR_ARBITER_ASSERT_EN defined and must pass with zero assertion failures.
